screen_write_ctrl: RTL and testbench

//   Sequences all writes into the 4096x8 text-screen character RAM and shares its single

---
 rtl/screen_pkg.sv | 40 ++++
 rtl/screen_write_ctrl_dec.sv | 70 +++++++
 rtl/screen_write_ctrl.sv | 122 ++++++++++++
 tb/tb_screen_write_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared constants, op codes, state types and ASCII helper for the screen writer
package screen_pkg;

   localparam int ADDR_W = 12;
   localparam int COLS   = 80;

   typedef enum logic [1:0] {
      OP_HEX   = 2'b00,
      OP_DEC   = 2'b01,
      OP_CLEAR = 2'b10,
      OP_CHAR  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONV,
      ST_WRITE,
      ST_CLEAR,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      DS_IDLE,
      DS_HUND,
      DS_TENS
   } dec_state_t;

   localparam logic [7:0] SPACE   = 8'h20;
   localparam logic [7:0] ZERO    = 8'h30;
   localparam logic [7:0] A_UPPER = 8'h41;

   // Uppercase hex digit for one nibble
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return ZERO + {4'h0, nib};
      else
         return A_UPPER + {4'h0, nib} - 8'd10;
   endfunction

endpackage

// File: rtl/screen_write_ctrl_dec.sv
// rtl/screen_write_ctrl_dec.sv - sequential byte to three ASCII decimal digits by repeated subtraction
module dec_byte_to_ascii (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] value,
   output logic       done,
   output logic [7:0] d2,
   output logic [7:0] d1,
   output logic [7:0] d0
);
   import screen_pkg::*;

   dec_state_t state_q, state_d;
   logic [7:0] rem;
   logic [3:0] hund;
   logic [3:0] tens;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= DS_IDLE;
      else       state_q <= state_d;
   end

   // Hundreds stage until remainder < 100, then tens stage until < 10; each end check costs a cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         DS_IDLE: if (start) state_d = DS_HUND;
         DS_HUND: if (rem < 8'd100) state_d = DS_TENS;
         DS_TENS: if (rem < 8'd10) state_d = DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   // One subtraction per cycle on the remainder, counting each digit
   always_ff @(posedge clk) begin
      if (reset) begin
         rem  <= 8'd0;
         hund <= 4'd0;
         tens <= 4'd0;
      end else begin
         case (state_q)
            DS_IDLE: if (start) begin
               rem  <= value;
               hund <= 4'd0;
               tens <= 4'd0;
            end
            DS_HUND: if (rem >= 8'd100) begin
               rem  <= rem - 8'd100;
               hund <= hund + 4'd1;
            end
            DS_TENS: if (rem >= 8'd10) begin
               rem  <= rem - 8'd10;
               tens <= tens + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Digits are valid in the done cycle; leading zeros blank, units always shown
   always_comb begin
      done = (state_q == DS_TENS) && (rem < 8'd10);
      d0   = ZERO + {4'h0, rem[3:0]};
      d1   = (hund == 4'd0 && tens == 4'd0) ? SPACE : ZERO + {4'h0, tens};
      d2   = (hund == 4'd0) ? SPACE : ZERO + {4'h0, hund};
   end

endmodule

// File: rtl/screen_write_ctrl.sv
// rtl/screen_write_ctrl.sv - print command sequencer sharing the character RAM port with video fetch
module screen_write_ctrl #(
   parameter int         ADDR_W     = 12,
   parameter int         DEPTH      = 4096,
   parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_data,
   input  logic              vid_active,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   output logic              busy,
   output logic              done
);
   import screen_pkg::*;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr;
   logic [1:0]        idx;
   logic [1:0]        last_idx;
   logic [7:0]        char_buf [0:3];
   logic              accept;
   logic              write_go;
   logic              dec_start;
   logic              dec_done;
   logic [7:0]        dec_d2, dec_d1, dec_d0;

   assign accept    = cmd_valid && cmd_ready;
   assign dec_start = accept && (cmd_op == OP_DEC);

   dec_byte_to_ascii u_dec (
      .clk   (clk),
      .reset (reset),
      .start (dec_start),
      .value (cmd_data),
      .done  (dec_done),
      .d2    (dec_d2),
      .d1    (dec_d1),
      .d0    (dec_d0)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state, handshake and RAM port mux; video always wins the port
   always_comb begin
      state_d   = state_q;
      cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
      write_go  = !vid_active && ((state_q == ST_WRITE) || (state_q == ST_CLEAR));
      ram_we    = write_go;
      ram_addr  = vid_active ? vid_addr : wr_ptr;
      ram_wdata = 8'h00;
      done      = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               case (cmd_op)
                  OP_DEC:   state_d = ST_CONV;
                  OP_CLEAR: state_d = ST_CLEAR;
                  default:  state_d = ST_WRITE;
               endcase
            end
         end
         ST_CONV:  if (dec_done) state_d = ST_WRITE;
         ST_WRITE: begin
            ram_wdata = char_buf[idx];
            if (write_go && idx == last_idx) state_d = ST_DONE;
         end
         ST_CLEAR: begin
            ram_wdata = CLEAR_CHAR;
            if (write_go && wr_ptr == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy = ~cmd_ready;
   end

   // Command latch, converted characters and write pointer; pointer and index hold while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         idx      <= 2'd0;
         last_idx <= 2'd0;
         for (int i = 0; i < 4; i++) char_buf[i] <= 8'h00;
      end else if (accept) begin
         wr_ptr <= (cmd_op == OP_CLEAR) ? '0 : cmd_addr;
         idx    <= 2'd0;
         case (cmd_op)
            OP_HEX: begin
               char_buf[0] <= hex_to_ascii(cmd_data[7:4]);
               char_buf[1] <= hex_to_ascii(cmd_data[3:0]);
               last_idx    <= 2'd1;
            end
            OP_DEC:  last_idx <= 2'd2;
            OP_CHAR: begin
               char_buf[0] <= cmd_data;
               last_idx    <= 2'd0;
            end
            default: last_idx <= 2'd0;
         endcase
      end else if (state_q == ST_CONV && dec_done) begin
         char_buf[0] <= dec_d2;
         char_buf[1] <= dec_d1;
         char_buf[2] <= dec_d0;
      end else if (write_go) begin
         wr_ptr <= wr_ptr + 1'b1;
         idx    <= idx + 2'd1;
      end
   end

endmodule

// File: tb/tb_screen_write_ctrl.sv
// tb/tb_screen_write_ctrl.sv - directed self-checking bench for screen_write_ctrl
module tb_screen_write_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [11:0] cmd_addr = 12'd0;
   logic [7:0]  cmd_data = 8'd0;
   logic        vid_active = 1'b0;
   logic [11:0] vid_addr = 12'd0;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:4095];
   logic        fill_req = 1'b0;

   int checks = 0;
   int errors = 0;

   screen_write_ctrl #(.ADDR_W(12), .DEPTH(4096), .CLEAR_CHAR(8'h20)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .vid_active (vid_active),
      .vid_addr   (vid_addr),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Screen RAM model, with a one-cycle fill to 8'hFF so untouched cells are visible
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'hFF;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic fill_mem();
      @(negedge clk);
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [7:0] data);
      int guard = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      while (!cmd_ready && guard < 10000) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL send_cmd: cmd_ready got %b required 1", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int lat);
      lat = 0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: ready/busy/done got %b%b%b required 100", cmd_ready, busy, done);
      end
      checks++;
      if (ram_we !== 1'b0 || ram_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_ram: we/wdata got %b/%h required 0/00", ram_we, ram_wdata);
      end
   endtask

   task automatic test_hex();
      int lat;
      send_cmd(2'b00, 12'd2449, 8'h3C);
      wait_done(20, lat);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL hex_latency: got %0d required 3", lat);
      end
      checks++;
      if (mem[2449] !== 8'h33 || mem[2450] !== 8'h43) begin
         errors++;
         $display("FAIL hex_data: got %h %h required 33 43", mem[2449], mem[2450]);
      end
   endtask

   task automatic test_dec();
      logic [7:0]  vals [3] = '{8'd7, 8'd255, 8'd0};
      logic [11:0] addrs [3] = '{12'd100, 12'd200, 12'd300};
      logic [23:0] exp_chars [3] = '{24'h202037, 24'h323535, 24'h202030};
      int          exp_lat [3] = '{6, 13, 6};
      int          lat;
      logic [23:0] got;
      for (int t = 0; t < 3; t++) begin
         send_cmd(2'b01, addrs[t], vals[t]);
         wait_done(40, lat);
         checks++;
         if (lat !== exp_lat[t]) begin
            errors++;
            $display("FAIL dec_latency[%0d]: got %0d required %0d", vals[t], lat, exp_lat[t]);
         end
         got = {mem[addrs[t]], mem[addrs[t] + 12'd1], mem[addrs[t] + 12'd2]};
         checks++;
         if (got !== exp_chars[t]) begin
            errors++;
            $display("FAIL dec_chars[%0d]: got %h required %h", vals[t], got, exp_chars[t]);
         end
      end
   endtask

   task automatic test_vid_stall();
      int viol = 0;
      int seen = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         vid_active = (((c + 2) / 4) % 2) == 1;
         vid_addr   = 12'((c * 37 + 5) % 4096);
         if (c == 0) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            cmd_addr  = 12'd600;
            cmd_data  = 8'hAB;
         end else begin
            cmd_valid = 1'b0;
         end
         #1;
         if (vid_active && (ram_we !== 1'b0 || ram_addr !== vid_addr)) viol++;
         if (done) begin
            seen = 1;
            break;
         end
      end
      vid_active = 1'b0;
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL vid_port: violations got %0d required 0", viol);
      end
      checks++;
      if (seen != 1) begin
         errors++;
         $display("FAIL vid_done: done seen got %0d required 1", seen);
      end
      checks++;
      if (mem[600] !== 8'h41 || mem[601] !== 8'h42) begin
         errors++;
         $display("FAIL vid_data: got %h %h required 41 42", mem[600], mem[601]);
      end
   endtask

   task automatic test_clear_char();
      int lat = 0;
      int bad = 0;
      fill_mem();
      send_cmd(2'b10, 12'd123, 8'h00);
      for (int k = 1; k <= 5000; k++) begin
         @(negedge clk);
         if (k == 1 || k == 2048) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
               errors++;
               $display("FAIL clear_ready[%0d]: got %b required 0", k, cmd_ready);
            end
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      checks++;
      if (lat !== 4097) begin
         errors++;
         $display("FAIL clear_latency: got %0d required 4097", lat);
      end
      send_cmd(2'b11, 12'd4095, 8'h56);
      wait_done(10, lat);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL char_latency: got %0d required 2", lat);
      end
      for (int i = 0; i < 4095; i++) if (mem[i] !== 8'h20) bad++;
      checks++;
      if (bad != 0 || mem[4095] !== 8'h56) begin
         errors++;
         $display("FAIL clear_contents: bad cells %0d, cell 4095 %h required 0, 56", bad, mem[4095]);
      end
   endtask

   task automatic test_wrap();
      int lat;
      send_cmd(2'b00, 12'd4095, 8'h5E);
      wait_done(20, lat);
      checks++;
      if (lat !== 3 || mem[4095] !== 8'h35 || mem[0] !== 8'h45 || mem[1] !== 8'h20) begin
         errors++;
         $display("FAIL wrap: lat %0d cells %h %h %h required 3 35 45 20", lat, mem[4095], mem[0], mem[1]);
      end
   endtask

   task automatic test_reset_mid_clear();
      int found = 0;
      int dones = 0;
      int bad_lo = 0;
      int bad_hi = 0;
      fill_mem();
      send_cmd(2'b10, 12'd0, 8'h00);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (ram_we && ram_addr == 12'd1000) begin
            found = 1;
            break;
         end
      end
      vid_active = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vid_active = 1'b0;
      #1;
      checks++;
      if (found != 1 || ram_we !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: found %0d we %b ready %b busy %b required 1 0 1 0", found, ram_we, cmd_ready, busy);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL reset_nodone: done pulses got %0d required 0", dones);
      end
      for (int i = 0; i < 1000; i++) if (mem[i] !== 8'h20) bad_lo++;
      for (int i = 1000; i < 4096; i++) if (mem[i] !== 8'hFF) bad_hi++;
      checks++;
      if (bad_lo != 0 || bad_hi != 0) begin
         errors++;
         $display("FAIL reset_cells: bad low %0d bad high %0d required 0 0", bad_lo, bad_hi);
      end
   endtask

   task automatic test_back_to_back();
      int lat = 0;
      int early_ready = 0;
      send_cmd(2'b00, 12'd20, 8'h12);
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_addr  = 12'd30;
      cmd_data  = 8'h51;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         if (cmd_ready) early_ready++;
      end
      checks++;
      if (lat !== 3 || cmd_ready !== 1'b1 || early_ready != 0) begin
         errors++;
         $display("FAIL b2b_ready: done at %0d ready %b early %0d required 3 1 0", lat, cmd_ready, early_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: busy got %b required 1", busy);
      end
      wait_done(10, lat);
      checks++;
      if (lat !== 1 || mem[30] !== 8'h51 || mem[20] !== 8'h31 || mem[21] !== 8'h32) begin
         errors++;
         $display("FAIL b2b_data: lat %0d cells %h %h %h required 1 51 31 32", lat, mem[30], mem[20], mem[21]);
      end
   endtask

   initial begin
      test_reset();
      test_hex();
      test_dec();
      test_vid_stall();
      test_clear_char();
      test_wrap();
      test_reset_mid_clear();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
